// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode pipeline definitions: fetch FSM states and the
// canonical bubble instruction, reused by decode flush logic.
package fetch_stage_pkg;

  // Fetch sequencer states. FAULT is only reachable in builds that trap
  // misaligned redirect targets.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0 -- presented whenever no real instruction is held
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between sequential instructions
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next fetch address selection: redirect target, sequential +4, or hold.
// Arithmetic wraps naturally at the address width.
module fetch_stage_pc_next
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] fetch_pc,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     redirect,
  input  logic                     advance,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic [ADDRESS_WIDTH-1:0] pc_next
);

  assign pc_plus4 = fetch_pc + ADDRESS_WIDTH'(PC_STEP);

  // Redirect wins over sequential advance; otherwise the PC holds
  assign pc_next = redirect ? redirect_target
                 : (advance ? pc_plus4 : fetch_pc);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, runs the req/ack handshake
// with instruction memory and presents instr/pc/pc+4 to the IF/ID register.
// Handles hazard stalls, execute redirects and drops fetches made stale by
// a redirect.
// Optional build macro FETCH_MISALIGN_EN: a redirect to a target whose low
// two bits are non-zero parks the stage in a sticky FAULT state and raises
// fetch_faultf. Without it the low target bits are ignored.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned                 ADDRESS_WIDTH = 32,
  parameter int unsigned                 DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]       NOP_INSTR     = DATA_WIDTH'(fetch_stage_pkg::NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stallf,
  input  logic                     pcsrce,
  input  logic [ADDRESS_WIDTH-1:0] pctargete,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instrf,
  output logic [ADDRESS_WIDTH-1:0] pcf,
  output logic [ADDRESS_WIDTH-1:0] pcplus4f,
  output logic                     validf
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                     fetch_faultf
`endif
);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] stale_addr;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic                     discard;
  logic                     hold_full;
  logic                     ack_taken;
  logic                     outstanding;
  logic                     capture;

`ifdef FETCH_MISALIGN_EN
  logic misaligned;
  assign redirect_target = pctargete;
  assign misaligned      = pcsrce && (pctargete[1:0] != 2'b00);
`else
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};
  assign redirect_target = pctargete & ALIGN_MASK;
`endif

  // A valid instruction the IF/ID register refuses: no room for another.
  // A capture always lands in the cycle after an ack, so this can never
  // coincide with a request that is still waiting for its ack.
  assign hold_full   = validf && stallf;
  assign imem_req    = (state == FETCH) && !hold_full;
  // While a stale request drains, the bus keeps the address it was issued with
  assign imem_addr   = discard ? stale_addr : fetch_pc;
  assign ack_taken   = imem_req && imem_ack;
  assign outstanding = imem_req && !imem_ack;
  // Redirects and draining stale requests both throw the returned word away
  assign capture     = ack_taken && !pcsrce && !discard;

  fetch_stage_pc_next #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_pc_next (
    .fetch_pc        (fetch_pc),
    .redirect_target (redirect_target),
    .redirect        (pcsrce),
    .advance         (capture),
    .pc_plus4        (pc_plus4),
    .pc_next         (pc_next)
  );

  // Fetch sequencer, fetch PC, stale-request tracking and IF/ID-facing registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      stale_addr <= RESET_PC;
      discard    <= 1'b0;
      pcf        <= RESET_PC;
      pcplus4f   <= RESET_PC + ADDRESS_WIDTH'(PC_STEP);
      instrf     <= NOP_INSTR;
      validf     <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      fetch_faultf <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the pre-edge values of the registers it reads.
      fetch_pc <= pc_next;

      // An unacked request caught by a redirect must still finish on the bus;
      // remember its address and drop its data when the ack comes back.
      if (pcsrce && outstanding) begin
        discard    <= 1'b1;
        stale_addr <= imem_addr;
      end else if (ack_taken) begin
        discard    <= 1'b0;
      end

      // Redirect flushes; otherwise capture, or empty out once IF/ID accepts
      if (pcsrce) begin
        validf <= 1'b0;
        instrf <= NOP_INSTR;
      end else if (capture) begin
        instrf   <= imem_rdata;
        pcf      <= fetch_pc;
        pcplus4f <= pc_plus4;
        validf   <= 1'b1;
      end else if (!stallf) begin
        validf <= 1'b0;
        instrf <= NOP_INSTR;
      end

`ifdef FETCH_MISALIGN_EN
      if (misaligned && (state != FAULT)) begin
        state        <= FAULT;
        fetch_faultf <= 1'b1;
      end else
`endif
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (!pcsrce && hold_full) state <= STALL;
        // A redirect empties the output registers, so fetching may resume
        STALL:   if (pcsrce || !stallf) state <= FETCH;
        default: state <= state;
      endcase
    end
  end

endmodule
